// File: rtl/ram_seq_pkg.sv
// ram_seq_pkg: shared types and sizes for the RAM burst sequencer.
// Build option RAM_SEQ_STATS_EN adds beat counters to ram_seq_ctrl.
package ram_seq_pkg;

    localparam int AW_DEF       = 4;
    localparam int DW_DEF       = 8;
    localparam int RD_BUF_DEPTH = 2;
    localparam int CNT_W        = $clog2(RD_BUF_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        RDRAIN
    } state_e;

endpackage

// File: rtl/ram_seq_rdbuf.sv
// ram_seq_rdbuf: 2-entry FIFO holding RAM read returns until the consumer takes them.
module ram_seq_rdbuf
    import ram_seq_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [DW-1:0]    din,
    output logic [DW-1:0]    dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [DW-1:0]    mem_q [RD_BUF_DEPTH];
    logic [DW-1:0]    mem_d [RD_BUF_DEPTH];
    logic             wp_q, wp_d;
    logic             rp_q, rp_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // When full, a push may only coincide with a pop; it lands in the slot being vacated.
    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wp_q] = din;
        wp_d  = wp_q ^ push;
        rp_d  = rp_q ^ pop;
        cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
            wp_q  <= 1'b0;
            rp_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    assign dout  = mem_q[rp_q];
    assign full  = cnt_q == CNT_W'(RD_BUF_DEPTH);
    assign empty = cnt_q == '0;
    assign count = cnt_q;

endmodule

// File: rtl/ram_seq_ctrl.sv
// ram_seq_ctrl: write/read burst sequencer in front of a synchronous RAM with 1-cycle read latency.
// Build option RAM_SEQ_STATS_EN adds saturating wr_beats/rd_beats handshake counters.
module ram_seq_ctrl
    import ram_seq_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_rd,
    input  logic [AW-1:0] cmd_addr,
    input  logic [AW-1:0] cmd_len,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [DW-1:0] wr_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [DW-1:0] rd_data,
    output logic          busy,
    output logic          done,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
`ifdef RAM_SEQ_STATS_EN
    ,
    output logic [15:0]   wr_beats,
    output logic [15:0]   rd_beats
`endif
);

    state_e           state_q, state_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic             inflight_q, inflight_d;
    logic             done_q, done_d;
    logic             wr_hs, pop, issue;
    logic             buf_full, buf_empty;
    logic [CNT_W-1:0] buf_count, occ_eff;
    logic [DW-1:0]    buf_dout;

    ram_seq_rdbuf #(.DW(DW)) u_rdbuf (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (inflight_q),
        .pop   (pop),
        .din   (ram_rdata),
        .dout  (buf_dout),
        .full  (buf_full),
        .empty (buf_empty),
        .count (buf_count)
    );

    // A slot freed by this cycle's pop is reusable immediately, giving one beat per cycle.
    always_comb begin
        wr_hs      = (state_q == WRITE) && wr_valid;
        pop        = ((state_q == READ) || (state_q == RDRAIN)) && rd_ready && !buf_empty;
        occ_eff    = buf_count - CNT_W'(pop);
        issue      = (state_q == READ) && !(buf_full && !pop)
                     && ((CNT_W + 1)'(occ_eff) + (CNT_W + 1)'(inflight_q) < (CNT_W + 1)'(RD_BUF_DEPTH));
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        case (state_q)
            IDLE: if (cmd_valid) begin
                addr_d  = cmd_addr;
                cnt_d   = cmd_len;
                state_d = cmd_rd ? READ : WRITE;
            end
            WRITE: if (wr_hs) begin
                addr_d  = addr_q + 1'b1;
                cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
                state_d = (cnt_q == '0) ? IDLE : WRITE;
            end
            READ: if (issue) begin
                addr_d  = addr_q + 1'b1;
                cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
                state_d = (cnt_q == '0) ? RDRAIN : READ;
            end
            default: state_d = (buf_empty && !inflight_q) ? IDLE : RDRAIN;
        endcase
        inflight_d = issue;
        done_d     = (state_d == IDLE) && (state_q != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            inflight_q <= inflight_d;
            done_q     <= done_d;
        end
    end

    assign cmd_ready = state_q == IDLE;
    assign busy      = state_q != IDLE;
    assign wr_ready  = state_q == WRITE;
    assign done      = done_q;
    assign ram_we    = wr_hs;
    assign ram_addr  = ((state_q == WRITE) || (state_q == READ)) ? addr_q : '0;
    assign ram_wdata = wr_hs ? wr_data : '0;
    assign rd_valid  = !buf_empty;
    assign rd_data   = buf_dout;

`ifdef RAM_SEQ_STATS_EN
    logic [15:0] wr_beats_q, wr_beats_d;
    logic [15:0] rd_beats_q, rd_beats_d;

    always_comb begin
        wr_beats_d = wr_beats_q + 16'(wr_hs && (wr_beats_q != 16'hFFFF));
        rd_beats_d = rd_beats_q + 16'(pop && (rd_beats_q != 16'hFFFF));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_beats_q <= '0;
            rd_beats_q <= '0;
        end else begin
            wr_beats_q <= wr_beats_d;
            rd_beats_q <= rd_beats_d;
        end
    end

    assign wr_beats = wr_beats_q;
    assign rd_beats = rd_beats_q;
`endif

endmodule

// File: tb/tb_ram_seq_ctrl.sv
// tb_ram_seq_ctrl: directed plus randomized bursts through ram_seq_ctrl into a 16x8 RAM model.
module tb_ram_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0, cmd_ready, cmd_rd = 1'b0;
    logic [3:0] cmd_addr = '0, cmd_len = '0;
    logic       wr_valid = 1'b0, wr_ready;
    logic [7:0] wr_data = '0;
    logic       rd_valid, rd_ready = 1'b0;
    logic [7:0] rd_data;
    logic       busy, done, ram_we;
    logic [3:0] ram_addr;
    logic [7:0] ram_wdata, ram_rdata;
`ifdef RAM_SEQ_STATS_EN
    logic [15:0] wr_beats, rd_beats;
`endif

    logic [7:0] mem [16];
    logic [7:0] ref_mem [16];
    logic [7:0] wbytes [16];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    ram_seq_ctrl #(.AW(4), .DW(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rd(cmd_rd),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .busy(busy), .done(done),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
`ifdef RAM_SEQ_STATS_EN
        , .wr_beats(wr_beats), .rd_beats(rd_beats)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
        chk({tag, "_wr_ready"}, wr_ready, 0);
        chk({tag, "_rd_valid"}, rd_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_ram_we"}, ram_we, 0);
        chk({tag, "_ram_addr"}, ram_addr, 0);
        chk({tag, "_ram_wdata"}, ram_wdata, 0);
    endtask

    task automatic send_cmd(input logic rd, input logic [3:0] a, input logic [3:0] l);
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_rd = rd; cmd_addr = a; cmd_len = l;
        @(negedge clk);
        chk("cmd_ready", cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_addr = 4'($urandom); cmd_len = 4'($urandom);
    endtask

    // One handshaked write beat at expected RAM address ea.
    task automatic write_beat(input logic [3:0] ea, input logic [7:0] b);
        wr_valid = 1'b1; wr_data = b;
        @(negedge clk);
        chk("wr_ready", wr_ready, 1);
        chk("wr_we", ram_we, 1);
        chk("wr_addr", ram_addr, ea);
        chk("wr_wdata", ram_wdata, b);
        chk("wr_no_early_done", done, 0);
        @(posedge clk);
        ref_mem[ea] = b;
        #1;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [3:0] l, input bit gaps);
        int ng;
        send_cmd(1'b0, a, l);
        for (int i = 0; i <= int'(l); i++) begin
            ng = gaps ? int'($urandom_range(0, 2)) : 0;
            for (int g = 0; g < ng; g++) begin
                wr_valid = 1'b0; wr_data = 8'($urandom);
                @(negedge clk);
                chk("wr_gap_we", ram_we, 0);
                chk("wr_gap_busy", busy, 1);
                @(posedge clk); #1;
            end
            write_beat(a + 4'(i), wbytes[i]);
        end
        wr_valid = 1'b0;
        @(negedge clk);
        chk("wr_done", done, 1);
        chk("wr_idle_cmd_ready", cmd_ready, 1);
        chk("wr_idle_busy", busy, 0);
        @(negedge clk);
        chk("wr_done_one_cycle", done, 0);
    endtask

    task automatic do_read(input logic [3:0] a, input logic [3:0] l, input bit rnd);
        logic [7:0] exp_q [$];
        int n, got, dones, first, last, cyc;
        logic pv, prdy;
        logic [7:0] pd;
        n = int'(l) + 1;
        for (int i = 0; i < n; i++) exp_q.push_back(ref_mem[a + 4'(i)]);
        send_cmd(1'b1, a, l);
        got = 0; dones = 0; first = 0; last = 0; pv = 1'b0; prdy = 1'b0; pd = '0;
        for (cyc = 0; cyc < 300 && !(got >= n && dones > 0); cyc++) begin
            rd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            chk("rd_no_we", ram_we, 0);
            if (pv && !prdy) begin
                chk("rd_hold_valid", rd_valid, 1);
                chk("rd_hold_data", rd_data, pd);
            end
            if (done) begin
                dones++;
                chk("rd_done_after_last", got, n);
            end
            if (rd_valid && rd_ready) begin
                if (got == 0) first = cyc;
                last = cyc;
                chk("rd_data", rd_data, (got < n) ? exp_q[got] : 8'hxx);
                got++;
            end
            pv = rd_valid; pd = rd_data; prdy = rd_ready;
            @(posedge clk); #1;
        end
        rd_ready = 1'b0;
        chk("rd_count", got, n);
        chk("rd_done_count", dones, 1);
        if (!rnd) chk("rd_consecutive", last - first, int'(l));
        @(negedge clk);
        chk("rd_done_one_cycle", done, 0);
        chk("rd_idle_busy", busy, 0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem[i] = '0;
            ref_mem[i] = '0;
        end
        #3;
        chk_reset_outputs("reset");
`ifdef RAM_SEQ_STATS_EN
        chk("reset_wr_beats", wr_beats, 0);
        chk("reset_rd_beats", rd_beats, 0);
`endif
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_cmd_ready", cmd_ready, 1);

        // write 11,22,33,44 at 2..5 back to back, then read back at full rate
        wbytes[0] = 8'h11; wbytes[1] = 8'h22; wbytes[2] = 8'h33; wbytes[3] = 8'h44;
        do_write(4'd2, 4'd3, 1'b0);
        do_read(4'd2, 4'd3, 1'b0);
`ifdef RAM_SEQ_STATS_EN
        chk("stats_wr_beats", wr_beats, 4);
        chk("stats_rd_beats", rd_beats, 4);
`endif

        // wrap-around burst 14,15,0,1
        for (int i = 0; i < 4; i++) wbytes[i] = 8'hA0 + 8'(i);
        do_write(4'd14, 4'd3, 1'b0);
        do_read(4'd14, 4'd3, 1'b0);

        // full-depth random write with gaps, then random-backpressure read
        for (int i = 0; i < 16; i++) wbytes[i] = 8'($urandom);
        do_write(4'($urandom), 4'd15, 1'b1);
        do_read(4'($urandom), 4'd15, 1'b1);
        do_read(4'($urandom), 4'($urandom), 1'b1);

        // reset in the middle of a write burst after two beats
        for (int i = 0; i < 8; i++) wbytes[i] = 8'($urandom);
        send_cmd(1'b0, 4'd6, 4'd7);
        write_beat(4'd6, wbytes[0]);
        write_beat(4'd7, wbytes[1]);
        wr_valid = 1'b1; wr_data = wbytes[2];
        #2 rst_n = 1'b0;
        #1;
        chk_reset_outputs("midburst_reset");
`ifdef RAM_SEQ_STATS_EN
        chk("midburst_wr_beats", wr_beats, 0);
        chk("midburst_rd_beats", rd_beats, 0);
`endif
        wr_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_abort_no_done", done, 0);
            chk("post_abort_cmd_ready", cmd_ready, 1);
        end
        do_read(4'd6, 4'd2, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
